// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control sequencer.
//   state_t          : FSM encoding, also driven out on the debug state port
//   DEF_CLK_HZ       : default board clock frequency
//   DEF_TICK_HZ      : default count-enable rate
//   DEF_DEBOUNCE_CYCLES : default stable-level time before a button change is accepted
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUNNING = 2'b01,
    LAP     = 2'b10,
    PAUSED  = 2'b11
  } state_t;

  localparam int DEF_CLK_HZ          = 50_000_000;
  localparam int DEF_TICK_HZ         = 1;
  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;

endpackage

// File: rtl/stopwatch_controller_button_conditioner.sv
// button_conditioner: turns one raw asynchronous push-button into a clean
// debounced level and a single-cycle press pulse.
//   clk    in  system clock
//   reset  in  asynchronous active-low reset
//   raw_in in  raw active-high button
//   level  out debounced button level
//   press  out one-cycle pulse on each accepted rising edge of level
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_in,
  output logic level,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic             db;
  logic             db_d;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      db    <= 1'b0;
      db_d  <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      s1    <= raw_in;
      s2    <= s1;
      db_d  <= db;
      // press is registered off db so it lands one edge after db flips
      press <= db & ~db_d;
      if (s2 == db) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        db  <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign level = db;

endmodule

// File: rtl/stopwatch_controller.sv
// stopwatch_controller: start/stop/lap/clear sequencer for the stopwatch
// datapath. Conditions both buttons, runs the control FSM and divides the
// board clock into the count-enable tick.
//   clk            in  system clock
//   reset          in  asynchronous active-low reset
//   btn_start_stop in  raw start/stop button
//   btn_lap_clear  in  raw lap/clear button
//   tick           out one-cycle count enable, every TICK_DIV cycles while counting
//   count_clear    out one-cycle counter clear
//   display_freeze out high while a lap is held
//   running        out high in RUNNING or LAP
//   state          out current FSM state (debug)
//
// state   | meaning
// IDLE    | stopped, prescaler zeroed; lap button clears the counter
// RUNNING | counting, display live
// LAP     | counting, display frozen
// PAUSED  | stopped, partial second kept in the prescaler
module stopwatch_controller
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ          = DEF_CLK_HZ,
  parameter int TICK_HZ         = DEF_TICK_HZ,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start_stop,
  input  logic       btn_lap_clear,
  output logic       tick,
  output logic       count_clear,
  output logic       display_freeze,
  output logic       running,
  output logic [1:0] state
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int PRE_W    = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

  localparam logic [1:0] ST_IDLE    = IDLE;
  localparam logic [1:0] ST_RUNNING = RUNNING;
  localparam logic [1:0] ST_LAP     = LAP;
  localparam logic [1:0] ST_PAUSED  = PAUSED;

  logic             start_press;
  logic             lap_press;
  logic [1:0]       state_q;
  logic [1:0]       next_state;
  logic             clear_nxt;
  logic             counting;
  logic [PRE_W-1:0] pre;

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_start (
    .clk    (clk),
    .reset  (reset),
    .raw_in (btn_start_stop),
    .level  (),
    .press  (start_press)
  );

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_lap (
    .clk    (clk),
    .reset  (reset),
    .raw_in (btn_lap_clear),
    .level  (),
    .press  (lap_press)
  );

  // start_stop is tested first everywhere, so a simultaneous lap press is dropped
  always_comb begin
    next_state = state_q;
    clear_nxt  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_press)    next_state = ST_RUNNING;
        else if (lap_press) clear_nxt  = 1'b1;
      end
      ST_RUNNING: begin
        if (start_press)    next_state = ST_PAUSED;
        else if (lap_press) next_state = ST_LAP;
      end
      ST_LAP: begin
        if (start_press)    next_state = ST_PAUSED;
        else if (lap_press) next_state = ST_RUNNING;
      end
      default: begin
        if (start_press) begin
          next_state = ST_RUNNING;
        end else if (lap_press) begin
          next_state = ST_IDLE;
          clear_nxt  = 1'b1;
        end
      end
    endcase
  end

  assign counting = (state_q == ST_RUNNING) || (state_q == ST_LAP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      pre            <= '0;
      tick           <= 1'b0;
      count_clear    <= 1'b0;
      display_freeze <= 1'b0;
      running        <= 1'b0;
    end else begin
      state_q <= next_state;
      // tick follows the state we were in, even on a transition edge
      if (counting) begin
        pre <= (pre == PRE_MAX) ? '0 : pre + 1'b1;
      end else if (next_state == ST_IDLE) begin
        pre <= '0;
      end
      tick           <= counting && (pre == PRE_MAX);
      count_clear    <= clear_nxt;
      display_freeze <= (next_state == ST_LAP);
      running        <= (next_state == ST_RUNNING) || (next_state == ST_LAP);
    end
  end

  assign state = state_q;

endmodule
